xilinx_block_ram_requester: RTL and testbench
=============================================

Name: xilinx_block_ram_requester

Overview:
- Initiator side of the single-port block RAM interface.
- Converts a valid/ready command stream (reads and byte-masked writes) into RAM port strobes.
- Tracks the RAM's fixed read latency and returns read data on a valid/ready response stream.
- Read responses are credit-limited, so backpressure never drops data. Sits between a core/DMA engine and one RAM instance.

Parameters:
- CLOCK_INFO, 'b0, std_clock_info_t; active clock edge; must match the attached RAM.
- DATA_WIDTH, 32, data width in bits; multiple of 8.
- ADDR_WIDTH, 10, word address width.
- MASK_WIDTH, DATA_WIDTH/8, byte write-enable width.
- READ_LATENCY, 1, RAM read latency in cycles; legal values 1 (no output register) or 2 (output register enabled).
- RESP_DEPTH, 4, response buffer entries; must be >= READ_LATENCY+1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_write_enable  in  MASK_WIDTH  byte mask; all-zero means read
- cmd_addr  in  ADDR_WIDTH  word address
- cmd_data  in  DATA_WIDTH  write data
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer accepts read data
- resp_data  out  DATA_WIDTH  read data
- ram_enable  out  1  RAM port enable
- ram_enable_output  out  1  RAM output-register enable
- ram_write_enable  out  MASK_WIDTH  RAM byte write enables
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_data_in  out  DATA_WIDTH  RAM write data
- ram_data_out  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (rst low, async): credit count=0, in-flight pipe cleared, FIFO empty, resp_valid=0, resp_data=0, cmd_ready=0 during reset.
- All state updates on the CLOCK_INFO edge.
- credits = in-flight reads + FIFO occupancy. cmd_ready = (credits < RESP_DEPTH), registered-free combinational from state only. cmd_ready never depends on cmd_valid or cmd payload, so writes are also stalled when credits are full.
- Accept = cmd_valid & cmd_ready.
- ram_enable = accept.
- ram_write_enable = accept ? cmd_write_enable : 0.
- ram_addr and ram_data_in pass through combinationally.
- ram_enable_output tied to 1: the RAM pipe always advances.
- In-flight tracker: shift register of READ_LATENCY bits. Bit 0 is set on accept of a read (mask==0). When the last stage is set, ram_data_out is pushed into the FIFO that cycle.
- Writes (mask!=0) consume no credit and generate no response. Partial-mask write returns nothing.
- Credit update: +1 on read accept, -1 on resp_valid & resp_ready. When both occur in one cycle, the net change is 0.
- FIFO: RESP_DEPTH entries, first-word registered output. resp_valid = FIFO non-empty. The first response appears READ_LATENCY+1 cycles after accept (latency includes the FIFO write cycle).
- FIFO never overflows, guaranteed by credits. Push and pop in the same cycle on a full FIFO is legal.
- Order: responses are returned strictly in command order.
- Read and write to the same address in consecutive cycles: the RAM's read-first semantics apply. The read returns the old data if issued in the same cycle as a write; there is no forwarding.
- resp_data is held stable while resp_valid & !resp_ready.
- Reset mid-operation: in-flight reads and buffered responses are discarded. No response is emitted after reset deasserts.

Optional Feature:
- Macro XILINX_BLOCK_RAM_REQUESTER_STATS_EN.
- Defined: adds outputs stat_reads [31:0] and stat_writes [31:0]. These increment on read/write accept, reset to 0, and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- std_pkg gains constant STD_BLOCK_RAM_MAX_LATENCY=2.
- The command struct typedef (write_enable, addr, data) goes in a new package, xilinx_block_ram_pkg.
- One sub-module: xilinx_block_ram_response_fifo (parameterised depth/width, registered output, async active-low reset).
- The credit counter and latency shift register live in the top module.

Test Plan:
- READ_LATENCY=1: write 0xDEADBEEF to addr 5 with mask 4'hF, then read addr 5 -> resp_data=0xDEADBEEF two cycles after the read accept; no response for the write.
- Byte mask: write 0x11223344 with mask 4'b0101 over 0x00000000, then read -> 0x00220044.
- READ_LATENCY=2, RESP_DEPTH=4, resp_ready=0: issue 6 reads -> cmd_ready falls after the 4th accept and exactly 4 entries buffer; release resp_ready -> 6 responses arrive in address order, with none lost or duplicated.
- Back-to-back reads to addresses 0..15 with resp_ready=1 -> one response per cycle in steady state and cmd_ready stays 1.
- Assert rst with 3 reads in flight -> resp_valid=0 immediately; after release, no stale responses and cmd_ready=1.
- With XILINX_BLOCK_RAM_REQUESTER_STATS_EN defined: 7 reads and 3 writes -> stat_reads=7 and stat_writes=3.

Source files
------------

// File: rtl/std_pkg.sv
// Library-wide base types and constants shared by standard RTL blocks.
package std_pkg;

    typedef enum logic {
        STD_CLOCK_POSEDGE = 1'b0,
        STD_CLOCK_NEGEDGE = 1'b1
    } std_clock_info_t;

    localparam int STD_BLOCK_RAM_MAX_LATENCY = 2;

endpackage

// File: rtl/xilinx_block_ram_pkg.sv
// Command type for block RAM requesters; sized for the widest supported RAM so
// that one typedef serves every instance width.
package xilinx_block_ram_pkg;

    localparam int XBR_MAX_DATA_WIDTH = 1024;
    localparam int XBR_MAX_ADDR_WIDTH = 32;
    localparam int XBR_MAX_MASK_WIDTH = XBR_MAX_DATA_WIDTH / 8;

    typedef struct packed {
        logic [XBR_MAX_MASK_WIDTH-1:0] write_enable;
        logic [XBR_MAX_ADDR_WIDTH-1:0] addr;
        logic [XBR_MAX_DATA_WIDTH-1:0] data;
    } xbr_cmd_t;

    function automatic logic xbr_is_read(input xbr_cmd_t cmd);
        return cmd.write_enable == '0;
    endfunction

endpackage

// File: rtl/xilinx_block_ram_response_fifo.sv
// Response buffer with a registered head word: o_data always holds the oldest
// entry, so the consumer sees a stable flop output.
module xilinx_block_ram_response_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop;
    logic [PW-1:0]    w_rptr_next;
    logic [CW-1:0]    w_count_after_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_pop             = i_pop && (r_count != '0);
    assign w_rptr_next       = w_pop ? ptr_inc(r_rptr) : r_rptr;
    assign w_count_after_pop = r_count - CW'(w_pop);

    always_ff @(posedge i_clk) begin
        if (i_push)
            r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            if (i_push)
                r_wptr <= ptr_inc(r_wptr);
            r_rptr  <= w_rptr_next;
            r_count <= w_count_after_pop + CW'(i_push);
            // An emptied buffer takes the incoming word straight into the head.
            if (w_count_after_pop == '0) begin
                if (i_push)
                    r_head <= i_data;
            end else begin
                r_head <= r_mem[w_rptr_next];
            end
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_head;

endmodule

// File: rtl/xilinx_block_ram_requester.sv
// Valid/ready front end for a single-port block RAM with credit-limited read returns.
// Optional XILINX_BLOCK_RAM_REQUESTER_STATS_EN adds stat_reads/stat_writes counters.
module xilinx_block_ram_requester
    import std_pkg::*;
    import xilinx_block_ram_pkg::*;
#(
    parameter std_clock_info_t CLOCK_INFO   = STD_CLOCK_POSEDGE,
    parameter int              DATA_WIDTH   = 32,
    parameter int              ADDR_WIDTH   = 10,
    parameter int              MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int              READ_LATENCY = 1,
    parameter int              RESP_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [MASK_WIDTH-1:0] cmd_write_enable,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  ram_enable,
    output logic                  ram_enable_output,
    output logic [MASK_WIDTH-1:0] ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef XILINX_BLOCK_RAM_REQUESTER_STATS_EN
    ,
    output logic [31:0]           stat_reads,
    output logic [31:0]           stat_writes
`endif
);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic                    w_clk;
    xbr_cmd_t                w_cmd;
    logic                    w_unused_cmd;
    logic                    w_is_read;
    logic                    w_accept;
    logic                    w_read_accept;
    logic                    w_push;
    logic                    w_pop;
    logic [CW-1:0]           r_credits;
    logic [READ_LATENCY-1:0] r_inflight;

    generate
        if (CLOCK_INFO == STD_CLOCK_NEGEDGE) begin : g_negedge
            assign w_clk = ~clk;
        end else begin : g_posedge
            assign w_clk = clk;
        end
    endgenerate

    always_comb begin
        w_cmd                              = '0;
        w_cmd.write_enable[MASK_WIDTH-1:0] = cmd_write_enable;
        w_cmd.addr[ADDR_WIDTH-1:0]         = cmd_addr;
        w_cmd.data[DATA_WIDTH-1:0]         = cmd_data;
    end
    assign w_unused_cmd = ^{w_cmd.addr, w_cmd.data};

    // Credits cover every read that could still land in the buffer, so a
    // RESP_DEPTH >= READ_LATENCY+1 buffer can never overflow.
    assign cmd_ready     = rst && (r_credits < CW'(RESP_DEPTH));
    assign w_is_read     = xbr_is_read(w_cmd);
    assign w_accept      = cmd_valid && cmd_ready;
    assign w_read_accept = w_accept && w_is_read;
    assign w_push        = r_inflight[READ_LATENCY-1];
    assign w_pop         = resp_valid && resp_ready;

    assign ram_enable        = w_accept;
    assign ram_enable_output = 1'b1;
    assign ram_write_enable  = w_accept ? w_cmd.write_enable[MASK_WIDTH-1:0] : '0;
    assign ram_addr          = w_cmd.addr[ADDR_WIDTH-1:0];
    assign ram_data_in       = w_cmd.data[DATA_WIDTH-1:0];

    always_ff @(posedge w_clk or negedge rst) begin
        if (!rst) begin
            r_credits  <= '0;
            r_inflight <= '0;
        end else begin
            r_inflight <= READ_LATENCY'({r_inflight, w_read_accept});
            if (w_read_accept && !w_pop)
                r_credits <= r_credits + CW'(1);
            else if (!w_read_accept && w_pop)
                r_credits <= r_credits - CW'(1);
        end
    end

    xilinx_block_ram_response_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_resp_fifo (
        .i_clk   (w_clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  (ram_data_out),
        .i_pop   (resp_ready),
        .o_valid (resp_valid),
        .o_data  (resp_data)
    );

`ifdef XILINX_BLOCK_RAM_REQUESTER_STATS_EN
    always_ff @(posedge w_clk or negedge rst) begin
        if (!rst) begin
            stat_reads  <= '0;
            stat_writes <= '0;
        end else begin
            if (w_read_accept)
                stat_reads <= stat_reads + 32'd1;
            if (w_accept && !w_is_read)
                stat_writes <= stat_writes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xilinx_block_ram_requester.sv
// Two requesters (read latency 1 and 2) each driving a behavioural read-first RAM,
// scored against a queue-based model of expected read returns.
module tb_xilinx_block_ram_requester;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] data;
        int          t;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_err;

    logic [1:0]       cmd_valid, cmd_ready, resp_valid, resp_ready, ram_en, ram_eo;
    logic [1:0][3:0]  cmd_we, ram_we;
    logic [1:0][9:0]  cmd_addr, ram_addr;
    logic [1:0][31:0] cmd_data, resp_data, ram_din, ram_dout;
`ifdef XILINX_BLOCK_RAM_REQUESTER_STATS_EN
    logic [1:0][31:0] stat_reads, stat_writes;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            localparam int L = g + 1;

            xilinx_block_ram_requester #(
                .READ_LATENCY (L),
                .RESP_DEPTH   (DEPTH)
            ) u_dut (
                .clk               (clk),
                .rst               (rst),
                .cmd_valid         (cmd_valid[g]),
                .cmd_ready         (cmd_ready[g]),
                .cmd_write_enable  (cmd_we[g]),
                .cmd_addr          (cmd_addr[g]),
                .cmd_data          (cmd_data[g]),
                .resp_valid        (resp_valid[g]),
                .resp_ready        (resp_ready[g]),
                .resp_data         (resp_data[g]),
                .ram_enable        (ram_en[g]),
                .ram_enable_output (ram_eo[g]),
                .ram_write_enable  (ram_we[g]),
                .ram_addr          (ram_addr[g]),
                .ram_data_in       (ram_din[g]),
                .ram_data_out      (ram_dout[g])
`ifdef XILINX_BLOCK_RAM_REQUESTER_STATS_EN
                ,
                .stat_reads        (stat_reads[g]),
                .stat_writes       (stat_writes[g])
`endif
            );

            // Read-first single-port RAM with optional output register.
            logic [31:0] mem [1024];
            logic [31:0] q1, q2;
            always @(posedge clk) begin
                if (ram_en[g]) begin
                    q1 <= mem[ram_addr[g]];
                    for (int b = 0; b < 4; b++)
                        if (ram_we[g][b]) mem[ram_addr[g]][8*b +: 8] <= ram_din[g][8*b +: 8];
                end
                if (ram_eo[g]) q2 <= q1;
            end
            assign ram_dout[g] = (L == 1) ? q1 : q2;

            // Reference: every accepted read owes exactly one response, in order,
            // visible L+1 cycles after its accept at the earliest.
            logic [31:0] ref_mem [1024];
            exp_t        q[$];
            int          rsp_cnt;
            initial begin : mon
                logic        exp_rdy, exp_vld, acc, held;
                logic [31:0] held_val;
                exp_t        e;
                rsp_cnt = 0;
                held = 1'b0;
                held_val = '0;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        q.delete();
                        held = 1'b0;
                    end else begin
                        exp_rdy = (q.size() < DEPTH);
                        exp_vld = (q.size() > 0) && (cyc >= q[0].t + L + 1);
                        acc     = cmd_valid[g] && exp_rdy;
                        chk("cmd_ready", 32'(cmd_ready[g]), 32'(exp_rdy));
                        chk("resp_valid", 32'(resp_valid[g]), 32'(exp_vld));
                        chk("ram_enable", 32'(ram_en[g]), 32'(acc));
                        chk("ram_we", 32'(ram_we[g]), acc ? 32'(cmd_we[g]) : 32'd0);
                        chk("ram_addr", 32'(ram_addr[g]), 32'(cmd_addr[g]));
                        if (held) chk("resp_hold", resp_data[g], held_val);
                        held     = resp_valid[g] && !resp_ready[g];
                        held_val = resp_data[g];
                        if (resp_valid[g] && resp_ready[g] && q.size() > 0) begin
                            chk("resp_data", resp_data[g], q[0].data);
                            void'(q.pop_front());
                            rsp_cnt++;
                        end
                        if (acc) begin
                            if (cmd_we[g] == 4'h0) begin
                                e.data = ref_mem[cmd_addr[g]];
                                e.t    = cyc;
                                q.push_back(e);
                            end else begin
                                for (int b = 0; b < 4; b++)
                                    if (cmd_we[g][b]) ref_mem[cmd_addr[g]][8*b +: 8] = cmd_data[g][8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    function automatic int get_rsp(input int d);
        return (d == 0) ? g_dut[0].rsp_cnt : g_dut[1].rsp_cnt;
    endfunction

    // Caller is just after a rising edge; returns just after the accepting edge.
    task automatic wait_accept(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready[d] && n < 300);
        chk("accept", 32'(cmd_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid[d] = 1'b0;
    endtask

    task automatic send(input int d, input logic [3:0] we, input logic [9:0] a, input logic [31:0] dat);
        cmd_valid[d] = 1'b1;
        cmd_we[d]    = we;
        cmd_addr[d]  = a;
        cmd_data[d]  = dat;
        wait_accept(d);
    endtask

    task automatic read_chk(input int d, input logic [9:0] a, input logic [31:0] exp, input string tag);
        int n;
        n = 0;
        send(d, 4'h0, a, 32'h0);
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid[d] && n < 20);
        chk(tag, resp_data[d], exp);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cmds(input int d, output int nrd);
        logic [3:0] we;
        nrd = 0;
        for (int i = 0; i < 120; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if (we == 4'h0) nrd++;
            send(d, we, 10'($urandom_range(0, 63)), $urandom);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base, base1, nrd0, nrd1, t0;
        logic done;
        n_chk = 0;
        n_err = 0;
        cmd_valid = '0;
        cmd_we = '0;
        cmd_addr = '0;
        cmd_data = '0;
        resp_ready = '1;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data0", resp_data[0], 32'd0);
        chk("rst_resp_data1", resp_data[1], 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 64; a++)
                send(d, 4'hF, 10'(a), $urandom);

        // Full write then read at latency 1: exact response cycle.
        send(0, 4'hF, 10'd5, 32'hDEADBEEF);
        repeat (3) begin
            @(negedge clk);
            chk("write_no_resp", 32'(resp_valid[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        send(0, 4'h0, 10'd5, 32'h0);
        @(negedge clk);
        chk("lat1_early", 32'(resp_valid[0]), 32'd0);
        @(negedge clk);
        chk("lat1_valid", 32'(resp_valid[0]), 32'd1);
        chk("lat1_data", resp_data[0], 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // Byte-masked write.
        for (int d = 0; d < 2; d++) begin
            send(d, 4'hF, 10'd7, 32'h0);
            send(d, 4'b0101, 10'd7, 32'h11223344);
            read_chk(d, 10'd7, 32'h00220044, "mask_data");
        end

        // Credit stall at latency 2 with consumer blocked.
        resp_ready[1] = 1'b0;
        base = get_rsp(1);
        for (int i = 0; i < 4; i++) send(1, 4'h0, 10'(20 + i), 32'h0);
        cmd_valid[1] = 1'b1;
        cmd_we[1]    = 4'h0;
        cmd_addr[1]  = 10'd24;
        repeat (4) begin
            @(negedge clk);
            chk("full_ready", 32'(cmd_ready[1]), 32'd0);
        end
        chk("full_valid", 32'(resp_valid[1]), 32'd1);
        @(posedge clk);
        #1 resp_ready[1] = 1'b1;
        wait_accept(1);
        send(1, 4'h0, 10'd25, 32'h0);
        repeat (20) @(negedge clk);
        chk("full_count", 32'(get_rsp(1) - base), 32'd6);
        @(posedge clk);
        #1;

        // Back-to-back reads: one accept per cycle, no stall.
        for (int d = 0; d < 2; d++) begin
            base = get_rsp(d);
            t0 = cyc;
            for (int i = 0; i < 16; i++) send(d, 4'h0, 10'(i), 32'h0);
            chk("b2b_cycles", 32'(cyc - t0), 32'd16);
            repeat (8) @(negedge clk);
            chk("b2b_count", 32'(get_rsp(d) - base), 32'd16);
            @(posedge clk);
            #1;
        end

        // Reset with reads in flight and buffered.
        resp_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) send(0, 4'h0, 10'(30 + i), 32'h0);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(resp_valid[0]), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_data", resp_data[0], 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        resp_ready = '1;
        base = get_rsp(0);
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd3);
        repeat (10) @(negedge clk);
        chk("post_rst_stale", 32'(get_rsp(0) - base), 32'd0);
        @(posedge clk);
        #1;

`ifdef XILINX_BLOCK_RAM_REQUESTER_STATS_EN
        for (int i = 0; i < 7; i++) send(0, 4'h0, 10'(i), 32'h0);
        for (int i = 0; i < 3; i++) send(0, 4'hF, 10'(40 + i), $urandom);
        @(negedge clk);
        chk("stat_reads", stat_reads[0], 32'd7);
        chk("stat_writes", stat_writes[0], 32'd3);
        chk("stat_reads1", stat_reads[1], 32'd0);
        @(posedge clk);
        #1;
`endif

        // Random traffic against random consumer backpressure.
        base  = get_rsp(0);
        base1 = get_rsp(1);
        done  = 1'b0;
        fork
            begin
                rand_cmds(0, nrd0);
                rand_cmds(1, nrd1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 resp_ready = 2'($urandom);
                end
                resp_ready = '1;
            end
        join
        repeat (20) @(negedge clk);
        chk("rand_count0", 32'(get_rsp(0) - base), 32'(nrd0));
        chk("rand_count1", 32'(get_rsp(1) - base1), 32'(nrd1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
